// File: rtl/opb_reg_pkg.sv
// Shared types, offsets and helpers for the OPB slave registers.
// Provides the ack FSM state enum, register offsets and byte-enable merge.
package opb_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } ack_state_e;

    // Word offsets taken from ABus[24:29]
    localparam logic [5:0] OFS_DATA = 6'h00;
    localparam logic [5:0] OFS_STAT = 6'h01;

    // Status bit positions in OPB (big-endian) numbering
    localparam int STAT_PEND = 31;
    localparam int STAT_OVR  = 30;

    // be[0] qualifies the most significant byte (OPB bits 0:7)
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [0:3]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                r[31-8*n -: 8] = new_w[31-8*n -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address hit detection and IDLE/ACK/WAIT transfer sequencing for OPB slaves.
// Ports: clk_i, rst_ni, select_i, abus_i -> start_o (hit accepted), ack_o.
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] BASEADDR = 32'h01000500,
    parameter logic [31:0] HIGHADDR = 32'h010005FF,
    parameter int          AWIDTH   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              select_i,
    input  logic [0:AWIDTH-1] abus_i,
    output logic              start_o,
    output logic              ack_o
);

    ack_state_e state_q;
    logic       ack_q;
    logic       hit;

    assign hit = select_i && (abus_i >= BASEADDR)
                 && (abus_i <= HIGHADDR);

    // The access itself happens in the top on this cycle
    assign start_o = (state_q == ST_IDLE) && hit;
    assign ack_o   = ack_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ST_ACK: state_q <= ST_WAIT;
                // Select held past the ack must not start a new transfer
                ST_WAIT: begin
                    if (!select_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/opb_register_ppc2simulink_hs.sv
// OPB write register (PPC -> fabric) with valid/ack handshake and status.
// Ports: OPB slave bus, user_data_out/valid/ack. Macro PPC2SIMULINK_READBACK_EN enables DATA reads.
module opb_register_ppc2simulink_hs
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010005FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter logic [31:0] C_INIT_VALUE = 32'h00000000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [31:0]             user_data_out,
    output logic                    user_data_valid,
    input  logic                    user_data_ack
);

    logic        start;
    logic [5:0]  ofs;
    logic        data_wr, stat_wr, data_rd, stat_rd;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic [0:31] rdata_q, rdata_d;
    logic [0:31] stat;
    logic        unused_ok;

    opb_slave_ack_fsm #(
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR),
        .AWIDTH   (C_OPB_AWIDTH)
    ) u_fsm (
        .clk_i    (OPB_Clk),
        .rst_ni   (OPB_Rst),
        .select_i (OPB_select),
        .abus_i   (OPB_ABus),
        .start_o  (start),
        .ack_o    (Sl_xferAck)
    );

    assign ofs     = OPB_ABus[24:29];
    assign data_wr = start && !OPB_RNW && (ofs == OFS_DATA);
    assign stat_wr = start && !OPB_RNW && (ofs == OFS_STAT);
    assign data_rd = start && OPB_RNW && (ofs == OFS_DATA);
    assign stat_rd = start && OPB_RNW && (ofs == OFS_STAT);

    always_comb begin
        stat            = '0;
        stat[STAT_PEND] = valid_q;
        stat[STAT_OVR]  = ovr_q;
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (data_wr) begin
            data_d  = be_merge(data_q, OPB_DBus, OPB_BE);
            valid_d = 1'b1;
            if (valid_q && !user_data_ack) begin
                ovr_d = 1'b1;
            end
        end else begin
            // A concurrent write keeps the new word pending
            if (user_data_ack) begin
                valid_d = 1'b0;
            end
            if (stat_wr && OPB_DBus[STAT_OVR]) begin
                ovr_d = 1'b0;
            end
        end
    end

    // Read data lives only for the ack cycle, zero otherwise
    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
`ifdef PPC2SIMULINK_READBACK_EN
            data_rd: rdata_d = data_q;
`endif
            stat_rd: rdata_d = stat;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            data_q  <= C_INIT_VALUE;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
        end
    end

    assign Sl_DBus         = rdata_q;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = data_q;
    assign user_data_valid = valid_q;

    assign unused_ok = ^{OPB_seqAddr, data_rd, (C_FAMILY != "")};

endmodule

// File: doc/opb_register_ppc2simulink_hs.md
Name: opb_register_ppc2simulink_hs

Overview:
- Single-clock OPB slave register carrying data in the PPC-to-fabric direction.
- The PPC writes a 32-bit word over OPB; the block drives it onto `user_data_out` and raises a valid/ack handshake toward user logic.
- A status register exposes "pending" and sticky "overrun" flags so software can pace its writes.
- Sits on the same OPB segment as the fabric-to-PPC registers, one instance per software-controlled parameter.

Parameters:
- C_BASEADDR, 32'h01000500, first byte address of the 256-byte window
- C_HIGHADDR, 32'h010005FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex5", target family string (informational)
- C_INIT_VALUE, 32'h00000000, data register value after reset

Ports:
- OPB_Clk  in  1  sole clock; OPB and user logic share it
- OPB_Rst  in  1  reset, asynchronous, active-low
- Sl_DBus  out  [0:31]  read data; all-zero except in the ack cycle
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- Sl_xferAck  out  1  transfer acknowledge, one-cycle pulse
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1=read, 0=write
- OPB_select  in  1  slave select qualifier
- OPB_seqAddr  in  1  ignored
- user_data_out  out  [31:0]  current data register; user bit 31-i = OPB bit i
- user_data_valid  out  1  new word pending for user logic
- user_data_ack  in  1  user consumed the word

Behaviour:
- Register map (byte offset from C_BASEADDR, bits in OPB numbering):
  - 0x0 DATA: R/W (read per optional feature).
  - 0x4 STATUS: bit31 = pending (RO), bit30 = overrun (write-1-to-clear); other bits read 0, writes ignored.
  - Other offsets in window: acknowledged; reads return 0; writes ignored.
- Hit condition: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The offset decode uses ABus[24:29].
- FSM states:
  - IDLE: on hit, perform the write or latch read data, then go to ACK.
  - ACK: Sl_xferAck=1 for exactly one cycle; Sl_DBus carries read data (zero on writes); always go to WAIT.
  - WAIT: hold until OPB_select=0, then go to IDLE. This prevents a double ack on a select held over.
- Latency: Sl_xferAck is asserted on the 2nd rising edge after the first cycle with a hit.
- DATA write: each byte n with BE[n]=1 replaces that byte; bytes with BE[n]=0 are retained. The update is visible on user_data_out the cycle after the IDLE write cycle.
- Handshake:
  - Any DATA write sets user_data_valid=1 in the same cycle the register updates.
  - valid clears on a cycle with user_data_ack=1 and no concurrent DATA write.
  - DATA write while valid=1 and ack=0: overrun sets (sticky); valid stays 1.
  - ack and DATA write in the same cycle: valid stays 1, no overrun.
  - ack while valid=0 is ignored.
- STATUS write with bit30=1 clears overrun. If an overrun occurs in the same cycle, set wins.
- Reset (OPB_Rst low, any time including mid-transfer):
  - FSM goes to IDLE; Sl_xferAck=0; Sl_DBus=0.
  - Data register = C_INIT_VALUE; valid=0; overrun=0.
  - An interrupted transfer is not acked; the master times out.

Optional Feature:
- Macro: PPC2SIMULINK_READBACK_EN.
  - Defined: DATA reads return the register contents in OPB bit order.
  - Undefined: DATA reads return 0 and the read mux is removed. STATUS stays readable either way.

Decomposition:
- Shared package opb_reg_pkg:
  - FSM state enum (IDLE, ACK, WAIT).
  - Offset constants OFS_DATA=6'h00, OFS_STAT=6'h01.
  - Status bit indices.
  - Function be_merge(old, new, be).
- Natural sub-module: opb_slave_ack_fsm. It covers hit detection and the IDLE/ACK/WAIT sequencing, and is reusable by the other OPB registers. The register and handshake logic stay in the top.

Test Plan:
- Reset, then read 0x4 → Sl_DBus=0; user_data_out=C_INIT_VALUE; valid=0.
- Write 0x01000500 with DBus=32'hDEADBEEF, BE=4'b1111 → xferAck exactly one cycle, 2 edges after select; user_data_out=32'hDEADBEEF; valid=1. Hold select 5 cycles → no second ack.
- Write 32'h11223344 with BE=4'b0101 over 32'hDEADBEEF → user_data_out=32'hDE22BE44. With readback enabled, a DATA read returns 32'hDE22BE44.
- Valid=1, write again without ack → STATUS read 32'h00000003. Write STATUS 32'h00000002 → reads 32'h00000001. Pulse ack → reads 0.
- Assert ack in the same cycle as a DATA write → valid stays 1; overrun stays 0.
- Drop OPB_Rst in the ACK-1 cycle (IDLE write done) → no xferAck; register=C_INIT_VALUE; valid=0. Next transaction after release completes normally.
